// File: rtl/slot_game_ctrl.sv
// Slot machine game controller: credit/bet bookkeeping, reels engine sequencing,
// paytable scoring and rate-limited payout of wins back into credits.
module slot_game_ctrl #(
  parameter int unsigned CREDIT_W    = 10,
  parameter int unsigned MAX_CREDITS = 999,
  parameter int unsigned MAX_BET     = 3,
  parameter int unsigned PAYOUT_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic                bet_btn,
  input  logic                spin_btn,
  input  logic                reels_done,
  input  logic [8:0]          reels_symbols,
  output logic                reels_start,
  output logic [CREDIT_W-1:0] credits,
  output logic [1:0]          bet,
  output logic [CREDIT_W-1:0] last_win,
  output logic                busy,
  output logic                payout_active
);

  localparam int unsigned         DIV_W    = (PAYOUT_DIV > 1) ? $clog2(PAYOUT_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PAYOUT_DIV - 1);
  localparam logic [CREDIT_W:0]   CRED_MAX = (CREDIT_W + 1)'(MAX_CREDITS);
  localparam logic [1:0]          BET_MAX  = 2'(MAX_BET);

  typedef enum logic [1:0] {
    IDLE,
    SPINNING,
    EVAL,
    PAYOUT
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [1:0]          bet_q, bet_d;
  logic [CREDIT_W-1:0] last_win_q, last_win_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                pay_act_q, pay_act_d;
  logic [8:0]          sym_q, sym_d;
  logic [CREDIT_W-1:0] pay_q, pay_d;
  logic [DIV_W-1:0]    div_q, div_d;

  logic [2:0]          s0, s1, s2;
  logic [1:0]          cherries;
  logic [6:0]          mult;
  logic [8:0]          win_full;
  logic [CREDIT_W-1:0] win;

  logic                spin_ok;
  logic                pay_tick;
  logic [CREDIT_W:0]   cred_sum;
  logic [CREDIT_W:0]   cred_sat;

  // Paytable: three-of-a-kind uses the fixed table, otherwise cherries pay.
  always_comb begin
    s0       = sym_q[2:0];
    s1       = sym_q[5:3];
    s2       = sym_q[8:6];
    cherries = 2'(s0 == 3'd0) + 2'(s1 == 3'd0) + 2'(s2 == 3'd0);
    mult     = '0;
    if ((s0 == s1) && (s1 == s2)) begin
      case (s0)
        3'd0:    mult = 7'd10;
        3'd1:    mult = 7'd5;
        3'd2:    mult = 7'd10;
        3'd3:    mult = 7'd15;
        3'd4:    mult = 7'd20;
        3'd5:    mult = 7'd25;
        3'd6:    mult = 7'd50;
        default: mult = 7'd100;
      endcase
    end else begin
      case (cherries)
        2'd0:    mult = 7'd0;
        2'd1:    mult = 7'd1;
        default: mult = 7'd3;
      endcase
    end
    win_full = {7'd0, bet_q} * {2'd0, mult};
    win      = CREDIT_W'(win_full);
  end

  always_comb begin
    state_d    = state_q;
    bet_d      = bet_q;
    last_win_d = last_win_q;
    start_d    = 1'b0;
    sym_d      = sym_q;
    pay_d      = pay_q;
    div_d      = div_q;
    spin_ok    = 1'b0;
    pay_tick   = 1'b0;

    case (state_q)
      IDLE: begin
        if (spin_btn && (credits_q >= CREDIT_W'(bet_q))) begin
          spin_ok    = 1'b1;
          last_win_d = '0;
          start_d    = 1'b1;
          state_d    = SPINNING;
        end else if (bet_btn) begin
          bet_d = (bet_q >= BET_MAX) ? 2'd1 : bet_q + 2'd1;
        end
      end
      SPINNING: begin
        if (reels_done) begin
          sym_d   = reels_symbols;
          state_d = EVAL;
        end
      end
      EVAL: begin
        last_win_d = win;
        if (win == '0) begin
          state_d = IDLE;
        end else begin
          pay_d   = win;
          div_d   = '0;
          state_d = PAYOUT;
        end
      end
      PAYOUT: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          pay_tick = 1'b1;
          pay_d    = pay_q - CREDIT_W'(1);
          if (pay_q == CREDIT_W'(1)) begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Coin and payout increments saturate first; the bet is debited from the saturated sum.
    cred_sum = {1'b0, credits_q} + (CREDIT_W + 1)'(coin_in) + (CREDIT_W + 1)'(pay_tick);
    cred_sat = (cred_sum > CRED_MAX) ? CRED_MAX : cred_sum;
    if (spin_ok) begin
      cred_sat = cred_sat - (CREDIT_W + 1)'(bet_q);
    end
    credits_d = cred_sat[CREDIT_W-1:0];

    busy_d    = (state_d != IDLE);
    pay_act_d = (state_d == PAYOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credits_q  <= '0;
      bet_q      <= 2'd1;
      last_win_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      pay_act_q  <= 1'b0;
      sym_q      <= '0;
      pay_q      <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      bet_q      <= bet_d;
      last_win_q <= last_win_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      pay_act_q  <= pay_act_d;
      sym_q      <= sym_d;
      pay_q      <= pay_d;
      div_q      <= div_d;
    end
  end

  assign reels_start   = start_q;
  assign credits       = credits_q;
  assign bet           = bet_q;
  assign last_win      = last_win_q;
  assign busy          = busy_q;
  assign payout_active = pay_act_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl: cycle-by-cycle vector table plus payout ramp sequences.
module tb_slot_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, coin_in, bet_btn, spin_btn, reels_done;
  logic [8:0] reels_symbols;
  logic       reels_start, busy, payout_active;
  logic [9:0] credits, last_win;
  logic [1:0] bet;

  int n_pass  = 0;
  int n_total = 0;

  slot_game_ctrl #(
    .CREDIT_W   (10),
    .MAX_CREDITS(999),
    .MAX_BET    (3),
    .PAYOUT_DIV (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .bet_btn      (bet_btn),
    .spin_btn     (spin_btn),
    .reels_done   (reels_done),
    .reels_symbols(reels_symbols),
    .reels_start  (reels_start),
    .credits      (credits),
    .bet          (bet),
    .last_win     (last_win),
    .busy         (busy),
    .payout_active(payout_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, c, b, s, d, sym;
    int cr, bt, lw, st, bz, pa;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input int r, c, b, s, d, sym, cr, bt, lw, st, bz, pa);
    vec_t v;
    v = '{r: r, c: c, b: b, s: s, d: d, sym: sym, cr: cr, bt: bt, lw: lw, st: st, bz: bz, pa: pa};
    q.push_back(v);
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input int r, c, b, s, d, sym);
    rst           = (r != 0);
    coin_in       = (c != 0);
    bet_btn       = (b != 0);
    spin_btn      = (s != 0);
    reels_done    = (d != 0);
    reels_symbols = 9'(sym);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    foreach (q[i]) begin
      cycle(q[i].r, q[i].c, q[i].b, q[i].s, q[i].d, q[i].sym);
      chk($sformatf("%s[%0d].credits", tag, i), credits, q[i].cr);
      chk($sformatf("%s[%0d].bet", tag, i), bet, q[i].bt);
      chk($sformatf("%s[%0d].last_win", tag, i), last_win, q[i].lw);
      chk($sformatf("%s[%0d].reels_start", tag, i), reels_start, q[i].st);
      chk($sformatf("%s[%0d].busy", tag, i), busy, q[i].bz);
      chk($sformatf("%s[%0d].payout_active", tag, i), payout_active, q[i].pa);
    end
    q.delete();
  endtask

  // Payout of win W lasts W*4 cycles; one credit lands every 4th cycle.
  task automatic run_payout(input string tag, input int win, input int c0, input int coin_at);
    int exp_cr;
    for (int n = 1; n <= win * 4; n++) begin
      cycle(0, (n == coin_at) ? 1 : 0, 0, 0, 0, 0);
      exp_cr = c0 + n / 4 + ((coin_at > 0 && n >= coin_at) ? 1 : 0);
      if (exp_cr > 999) exp_cr = 999;
      chk($sformatf("%s[%0d].credits", tag, n), credits, exp_cr);
      chk($sformatf("%s[%0d].payout_active", tag, n), payout_active, (n < win * 4) ? 1 : 0);
      chk($sformatf("%s[%0d].busy", tag, n), busy, (n < win * 4) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // r  c  b  s  d  sym     cr   bt lw   st bz pa
    add(1, 0, 0, 0, 0, 0,      0,   1, 0,   0, 0, 0);   // reset state
    add(0, 0, 0, 1, 0, 0,      0,   1, 0,   0, 0, 0);   // spin with no credits
    add(0, 0, 1, 0, 0, 0,      0,   2, 0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      0,   3, 0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      0,   1, 0,   0, 0, 0);   // bet wraps to 1
    for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 0, i, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      5,   2, 0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      5,   3, 0,   0, 0, 0);
    add(0, 0, 0, 1, 0, 0,      2,   3, 0,   1, 1, 0);   // spin accepted
    add(0, 0, 0, 0, 0, 0,      2,   3, 0,   0, 1, 0);   // start is one cycle
    add(0, 0, 1, 0, 0, 0,      2,   3, 0,   0, 1, 0);   // bet ignored while spinning
    add(0, 0, 0, 1, 0, 0,      2,   3, 0,   0, 1, 0);   // spin ignored while spinning
    add(0, 0, 0, 0, 1, 'h1FF,  2,   3, 0,   0, 1, 0);   // {7,7,7} -> EVAL
    add(0, 0, 0, 0, 0, 0,      2,   3, 300, 0, 1, 1);   // EVAL -> PAYOUT
    run_table("jackpot");
    run_payout("jackpot_pay", 300, 2, 0);

    add(0, 0, 1, 0, 0, 0,      302, 1, 300, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      302, 2, 300, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,      300, 2, 0,   1, 1, 0);   // last_win cleared on spin
    add(0, 0, 0, 0, 0, 0,      300, 2, 0,   0, 1, 0);
    add(0, 0, 0, 0, 1, 'h0C0,  300, 2, 0,   0, 1, 0);   // {3,0,0}
    add(0, 0, 0, 0, 0, 0,      300, 2, 6,   0, 1, 1);   // 2 cherries * bet 2
    run_table("cherries");
    run_payout("cherries_pay", 6, 300, 0);

    add(0, 0, 0, 1, 0, 0,      304, 2, 0,   1, 1, 0);
    add(0, 0, 0, 0, 0, 0,      304, 2, 0,   0, 1, 0);
    add(0, 0, 0, 0, 1, 'h053,  304, 2, 0,   0, 1, 0);   // {1,2,3}
    add(0, 0, 0, 0, 0, 0,      304, 2, 0,   0, 0, 0);   // no win: straight to IDLE
    add(0, 0, 0, 0, 0, 0,      304, 2, 0,   0, 0, 0);
    run_table("nowin");

    for (int i = 0; i < 700; i++) cycle(0, 1, 0, 0, 0, 0);
    chk("coin_fill.credits", credits, 999);
    add(0, 1, 0, 0, 0, 0,      999, 2, 0,   0, 0, 0);   // coin at ceiling
    add(0, 0, 1, 0, 0, 0,      999, 3, 0,   0, 0, 0);
    add(0, 0, 1, 0, 0, 0,      999, 1, 0,   0, 0, 0);
    add(0, 0, 1, 1, 0, 0,      998, 1, 0,   1, 1, 0);   // spin+bet: spin wins, bet kept
    add(0, 0, 0, 0, 0, 0,      998, 1, 0,   0, 1, 0);
    add(0, 0, 0, 0, 1, 'h092,  998, 1, 0,   0, 1, 0);   // {2,2,2}
    add(0, 0, 0, 0, 0, 0,      998, 1, 10,  0, 1, 1);
    run_table("sat");
    run_payout("sat_pay", 10, 998, 2);

    add(0, 0, 0, 1, 0, 0,      998, 1, 0,   1, 1, 0);
    add(1, 0, 0, 0, 0, 0,      0,   1, 0,   0, 0, 0);   // reset mid-spin
    add(0, 0, 0, 0, 1, 'h1FF,  0,   1, 0,   0, 0, 0);   // stale done ignored
    add(0, 0, 0, 0, 0, 0,      0,   1, 0,   0, 0, 0);
    run_table("rst_spin");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
